// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrow-store read-modify-write path:
// size encodings, controller states and the wait-counter sizing.
package store_narrow_rmw_pkg;

  // Store size encodings as presented on req_size (2'b11 is illegal).
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Largest supported memory read latency; sizes the wait counter.
  localparam int unsigned MAX_MEM_LAT = 4;
  localparam int unsigned LAT_CNT_W   = $clog2(MAX_MEM_LAT);

  // Controller states; dispatch happens directly out of IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A request is rejected when its size is illegal or its address is not
  // naturally aligned for that size. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_narrow_rmw_byte_lane_merge.sv
// Little-endian lane merge: overlays the low byte/halfword of a register
// value onto an existing memory word at the lane(s) chosen by addr_lo.
// Purely combinational so the load path can reuse it for lane selection.
module byte_lane_merge
  import store_narrow_rmw_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] req_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Start from the old word and replace only the lanes being stored.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        merged[{addr_lo, 3'b000} +: 8] = req_data[7:0];
      end
      SZ_HALF: begin
        if (addr_lo[1]) begin
          merged[31:16] = req_data[15:0];
        end else begin
          merged[15:0] = req_data[15:0];
        end
      end
      SZ_WORD: begin
        merged = req_data;
      end
      default: begin
        merged = old_word;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: byte/halfword stores are performed as a
// read-modify-write of the containing word, word stores go straight to a
// write, and misaligned or illegal requests complete with misalign set
// without touching memory. Every output is a register.
module store_narrow_rmw
  import store_narrow_rmw_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        misalign,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Wait-counter value of the last WAIT cycle, where read data is valid.
  localparam logic [LAT_CNT_W-1:0] LAST_WAIT = LAT_CNT_W'(MEM_LAT - 1);

  state_e               state_r;
  logic [LAT_CNT_W-1:0] wait_cnt_r;
  logic [31:0]          data_r;
  logic [1:0]           size_r;
  logic [1:0]           off_r;
  logic [31:0]          merged_s;
  logic                 accept_s;
  logic                 reject_s;

  // req_ready is a registered copy of (state == IDLE), so this is the handshake.
  assign accept_s = req_valid && req_ready;
  assign reject_s = is_misaligned(req_size, req_addr[1:0]);

  // Read data is only consumed on the last WAIT cycle; other cycles ignore it.
  byte_lane_merge u_merge (
    .old_word (mem_rdata),
    .req_data (data_r),
    .size     (size_r),
    .addr_lo  (off_r),
    .merged   (merged_s)
  );

  // Controller: state sequencing plus registered handshake and memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      data_r     <= 32'h0000_0000;
      size_r     <= SZ_BYTE;
      off_r      <= 2'b00;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      misalign   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 30'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            data_r    <= req_data;
            size_r    <= req_size;
            off_r     <= req_addr[1:0];
            req_ready <= 1'b0;
            if (reject_s) begin
              state_r  <= ST_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_r   <= ST_WRITE;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[31:2];
              mem_wdata <= req_data;
            end else begin
              state_r  <= ST_READ;
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= req_addr[31:2];
            end
          end
        end
        ST_READ: begin
          state_r    <= ST_WAIT;
          mem_en     <= 1'b0;
          wait_cnt_r <= '0;
        end
        ST_WAIT: begin
          if (wait_cnt_r == LAST_WAIT) begin
            state_r   <= ST_WRITE;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= merged_s;
          end else begin
            wait_cnt_r <= wait_cnt_r + LAT_CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state_r <= ST_DONE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          done      <= 1'b0;
          misalign  <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          done      <= 1'b0;
          misalign  <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Scoreboard bench for store_narrow_rmw. Two instances (MEM_LAT=1 and 3)
// are exercised one at a time. The driver pushes expected memory/done
// events with their cycle numbers; a negedge monitor pops and compares.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [1:0]  req_size  [2];
  logic        done      [2];
  logic        misalign  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [29:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    store_narrow_rmw #(.MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .req_data  (req_data[g]),
      .req_size  (req_size[g]),
      .done      (done[g]),
      .misalign  (misalign[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  typedef struct {
    int          inst;
    int          cyc;
    int          kind;   // 0 read, 1 write, 2 done
    logic [29:0] addr;
    logic [31:0] data;
    logic        mis;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mem_phys [bit [30:0]];
  logic [31:0] mem_ref  [bit [30:0]];
  int          rd_due   [2] = '{-10, -10};
  logic [31:0] rd_word  [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit [30:0] key_of(input int i, input logic [31:0] a);
    return {i[0], a[31:2]};
  endfunction

  function automatic logic [31:0] init_word(input bit [30:0] k);
    return {k[15:0], ~k[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] phys_get(input bit [30:0] k);
    return mem_phys.exists(k) ? mem_phys[k] : init_word(k);
  endfunction

  function automatic logic [31:0] ref_get(input bit [30:0] k);
    return mem_ref.exists(k) ? mem_ref[k] : init_word(k);
  endfunction

  // Reference: split the word into bytes, replace the stored bytes, rejoin.
  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] s);
    logic [7:0] b [4];
    int k;
    k = int'(a % 32'd4);
    for (int j = 0; j < 4; j++) b[j] = old[8*j +: 8];
    if (s == 2'd0) begin
      b[k] = d[7:0];
    end else if (s == 2'd1) begin
      b[k]   = d[7:0];
      b[k+1] = d[15:8];
    end else begin
      for (int j = 0; j < 4; j++) b[j] = d[8*j +: 8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name, input int i, input logic [31:0] a,
                           input logic [31:0] exp);
    check(name, phys_get(key_of(i, a)), exp);
  endtask

  task automatic observe(input int i, input int kind, input logic [29:0] a,
                         input logic [31:0] d, input logic mis);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event inst=%0d cyc=%0d kind=%0d addr=%h data=%h mis=%0b required none",
               i, cyc, kind, a, d, mis);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != i || e.kind != kind || e.cyc != cyc || e.addr != a ||
          e.data != d || e.mis != mis) begin
        failures++;
        $display("FAIL event actual inst=%0d cyc=%0d kind=%0d addr=%h data=%h mis=%0b required inst=%0d cyc=%0d kind=%0d addr=%h data=%h mis=%0b",
                 i, cyc, kind, a, d, mis, e.inst, e.cyc, e.kind, e.addr, e.data, e.mis);
      end
    end
  endtask

  // Monitor: memory model, scoreboard pops and garbage on rdata when not due.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_en[i]) begin
          if (mem_we[i]) begin
            observe(i, 1, mem_addr[i], mem_wdata[i], 1'b0);
            mem_phys[{i[0], mem_addr[i]}] = mem_wdata[i];
          end else begin
            observe(i, 0, mem_addr[i], 32'h0, 1'b0);
            rd_word[i] <= phys_get({i[0], mem_addr[i]});
            rd_due[i]  <= cyc + lat_of(i);
          end
        end
        if (done[i]) observe(i, 2, 30'h0, 32'h0, misalign[i]);
        if (misalign[i] && !done[i]) check("misalign_without_done", 32'(misalign[i]), 32'h0);
      end
    end
    for (int i = 0; i < 2; i++) mem_rdata[i] <= (cyc == rd_due[i]) ? rd_word[i] : $urandom;
  end

  task automatic preload(input int i, input logic [31:0] a, input logic [31:0] w);
    mem_phys[key_of(i, a)] = w;
    mem_ref[key_of(i, a)]  = w;
  endtask

  // Present a request, wait for acceptance, push its expected events.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit hold, output int c0);
    int          n;
    bit [30:0]   k;
    logic [31:0] nw;
    bit          err;
    int          lat;
    lat = lat_of(i);
    k   = key_of(i, a);
    @(negedge clk);
    req_addr[i] = a; req_data[i] = d; req_size[i] = s; req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 100) begin @(negedge clk); n++; end
    if (!req_ready[i]) begin
      checks++; failures++;
      $display("FAIL accept_timeout inst=%0d actual ready=0 required ready=1", i);
      req_valid[i] = 1'b0; c0 = -1;
      return;
    end
    c0 = cyc;
    @(posedge clk);
    err = (s == 2'd3) || (s == 2'd1 && a % 32'd2 != 0) || (s == 2'd2 && a % 32'd4 != 0);
    if (err) begin
      exp_q.push_back('{inst:i, cyc:c0+1, kind:2, addr:30'h0, data:32'h0, mis:1'b1});
    end else if (s == 2'd2) begin
      exp_q.push_back('{inst:i, cyc:c0+1, kind:1, addr:a[31:2], data:d, mis:1'b0});
      exp_q.push_back('{inst:i, cyc:c0+2, kind:2, addr:30'h0, data:32'h0, mis:1'b0});
      mem_ref[k] = d;
    end else begin
      nw = model_merge(ref_get(k), a, d, s);
      exp_q.push_back('{inst:i, cyc:c0+1, kind:0, addr:a[31:2], data:32'h0, mis:1'b0});
      exp_q.push_back('{inst:i, cyc:c0+2+lat, kind:1, addr:a[31:2], data:nw, mis:1'b0});
      exp_q.push_back('{inst:i, cyc:c0+3+lat, kind:2, addr:30'h0, data:32'h0, mis:1'b0});
      mem_ref[k] = nw;
    end
    #1;
    req_addr[i] = $urandom; req_data[i] = $urandom; req_size[i] = 2'($urandom);
    req_valid[i] = hold;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready[i]) && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || !req_ready[i]) begin
      checks++; failures++;
      $display("FAIL drain_timeout inst=%0d actual pending=%0d required pending=0", i, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag, input int i);
    check($sformatf("%s_ready_%0d", tag, i), 32'(req_ready[i]), 32'h1);
    check($sformatf("%s_done_%0d", tag, i), 32'(done[i]), 32'h0);
    check($sformatf("%s_misalign_%0d", tag, i), 32'(misalign[i]), 32'h0);
    check($sformatf("%s_mem_en_%0d", tag, i), 32'(mem_en[i]), 32'h0);
    check($sformatf("%s_mem_we_%0d", tag, i), 32'(mem_we[i]), 32'h0);
    check($sformatf("%s_mem_addr_%0d", tag, i), 32'(mem_addr[i]), 32'h0);
    check($sformatf("%s_mem_wdata_%0d", tag, i), mem_wdata[i], 32'h0);
  endtask

  task automatic random_ops(input int i, input int count);
    logic [31:0] a;
    logic [1:0]  s;
    bit          hold;
    int          c;
    for (int n = 0; n < count; n++) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom);
      s    = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 2) != 0) && (n != count - 1);
      issue(i, a, $urandom, s, hold, c);
      if (!hold && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    req_valid[i] = 1'b0;
    wait_idle(i);
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = 32'h0; req_data[i] = 32'h0; req_size[i] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) check_reset_outputs("reset", i);
    rst_n = 1'b1;

    // Byte store into the middle of a word.
    preload(0, 32'h100, 32'h1122_3344);
    issue(0, 32'h102, 32'hFFFF_FFAB, 2'b00, 1'b0, c);
    wait_idle(0);
    check_mem("sb_0x102", 0, 32'h100, 32'h11AB_3344);

    // Halfword stores into upper and lower halves.
    preload(0, 32'h200, 32'hAAAA_AAAA);
    issue(0, 32'h202, 32'h0000_BEEF, 2'b01, 1'b0, c);
    wait_idle(0);
    check_mem("sh_0x202", 0, 32'h200, 32'hBEEF_AAAA);
    preload(0, 32'h200, 32'hAAAA_AAAA);
    issue(0, 32'h200, 32'h0000_BEEF, 2'b01, 1'b0, c);
    wait_idle(0);
    check_mem("sh_0x200", 0, 32'h200, 32'hAAAA_BEEF);

    // Word store.
    issue(0, 32'h300, 32'hDEAD_BEEF, 2'b10, 1'b0, c);
    wait_idle(0);
    check_mem("sw_0x300", 0, 32'h300, 32'hDEAD_BEEF);

    // Rejected requests leave memory alone.
    preload(0, 32'h400, 32'h0102_0304);
    issue(0, 32'h101, 32'h0000_1234, 2'b01, 1'b0, c);
    issue(0, 32'h302, 32'h5555_5555, 2'b10, 1'b0, c);
    issue(0, 32'h400, 32'h6666_6666, 2'b11, 1'b0, c);
    wait_idle(0);
    check_mem("mis_sh_unchanged", 0, 32'h100, 32'h11AB_3344);
    check_mem("mis_sw_unchanged", 0, 32'h300, 32'hDEAD_BEEF);
    check_mem("ill_unchanged", 0, 32'h400, 32'h0102_0304);

    // Reset while waiting for read data.
    preload(0, 32'h104, 32'h5566_7788);
    issue(0, 32'h105, 32'h0000_0077, 2'b00, 1'b0, c);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait", 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_mem("rst_wait_unchanged", 0, 32'h104, 32'h5566_7788);
    mem_ref[key_of(0, 32'h104)] = 32'h5566_7788;

    // Reset while the write strobe is up.
    issue(0, 32'h106, 32'h0000_0099, 2'b00, 1'b0, c);
    @(posedge clk); @(posedge clk); #1;
    check("write_cycle_mem_en", 32'(mem_en[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_write_mem_en", 32'(mem_en[0]), 32'h0);
    check("rst_write_mem_we", 32'(mem_we[0]), 32'h0);
    check("rst_write_done", 32'(done[0]), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_mem("rst_write_unchanged", 0, 32'h104, 32'h5566_7788);
    mem_ref[key_of(0, 32'h104)] = 32'h5566_7788;

    preload(0, 32'h100, 32'h1122_3344);
    issue(0, 32'h103, 32'h0000_005A, 2'b00, 1'b0, c);
    wait_idle(0);
    check_mem("sb_after_reset", 0, 32'h100, 32'h5A22_3344);

    random_ops(0, 60);

    // MEM_LAT=3: back-to-back byte stores with req_valid held.
    preload(1, 32'h500, 32'h1122_3344);
    preload(1, 32'h600, 32'hCAFE_F00D);
    issue(1, 32'h501, 32'h0000_00EE, 2'b00, 1'b1, c1);
    issue(1, 32'h602, 32'h0000_0099, 2'b00, 1'b0, c2);
    check("b2b_accept_gap", 32'(c2 - c1), 32'd7);
    wait_idle(1);
    check_mem("lat3_sb_0x501", 1, 32'h500, 32'h1122_EE44);
    check_mem("lat3_sb_0x602", 1, 32'h600, 32'hCA99_F00D);

    random_ops(1, 30);

    foreach (mem_ref[k]) check($sformatf("final_mem_%h", k), phys_get(k), mem_ref[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
